spi_sensor_responder: RTL and testbench

Synthesizable SPI responder that models the multichannel sensor at the far end of `main`'s SPI link: it receives 16-bit command frames on `MOSI_to_sensor` and returns replies on `MISO_from_sensor`. The reply to each command is returned two frames later, as the real sensor does. The block sits beside `main` in `mainTB` and in loopback FPGA builds, replacing the physical sensor. It also exposes decoded commands for scoreboarding.

---
 rtl/spi_sensor_pkg.sv | 39 +++
 rtl/spi_sensor_responder_edge_sync.sv | 26 ++
 rtl/spi_sensor_responder.sv | 195 +++++++++++++++++++
 tb/tb_spi_sensor_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sensor_pkg.sv
// Shared constants and types for the SPI sensor responder.
// Opcodes, FSM states, read-only register map and reply sentinel.
package spi_sensor_pkg;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_DUMMY   = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [5:0] RO_BASE  = 6'd60;
  localparam logic [7:0] RO_VAL60 = 8'h01;
  localparam logic [7:0] RO_VAL61 = 8'h53;
  localparam logic [7:0] RO_VAL62 = 8'h49;

  localparam logic [15:0] REPLY_DEAD = 16'hDEAD;

  // Value of a read-only register; reg63 reports the channel count.
  function automatic logic [7:0] ro_value(
    input logic [1:0] idx,
    input logic [7:0] nch
  );
    logic [7:0] v;
    v = nch;
    unique case (idx)
      2'd0:    v = RO_VAL60;
      2'd1:    v = RO_VAL61;
      2'd2:    v = RO_VAL62;
      default: v = nch;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/spi_sensor_responder_edge_sync.sv
// Two-flop synchronizer with rise/fall pulse detection.
// One instance per asynchronous SPI input.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sh;

  // Two sync stages plus one history stage for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) r_sh <= {3{RST_VAL}};
    else        r_sh <= {r_sh[1:0], i_d};
  end

  assign o_lvl  = r_sh[1];
  assign o_rise = r_sh[1] & ~r_sh[2];
  assign o_fall = ~r_sh[1] & r_sh[2];

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI responder modelling the multichannel sensor.
// Replies to each command two frames later.
module spi_sensor_responder
  import spi_sensor_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int N_CHANNELS = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK_wire,
  input  logic              CS_b_wire,
  input  logic              MOSI_to_sensor,
  output logic              MISO_from_sensor,
  output logic              cmd_valid,
  output logic [WORD_W-1:0] cmd_word,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_W);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused_sync;

  state_t r_state, w_next;
  logic   w_start, w_accept, w_short;

  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_tx;
  logic              r_pend;
  logic [WORD_W-1:0] r_cmd_word;
  logic              r_frame_err;

  logic [WORD_W-1:0] r_pipe [PIPE_DEPTH];
  logic [7:0]        r_regs [64];
  logic [9:0]        r_conv;

  logic [1:0]        w_op;
  logic [5:0]        w_addr;
  logic [7:0]        w_data;
  logic [7:0]        w_rdata;
  logic [WORD_W-1:0] w_reply;
  logic              w_wr_en;
  logic              w_conv_inc;

  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk    (clk),
    .reset  (reset),
    .i_d    (SCLK_wire),
    .o_lvl  (w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_cs (
    .clk    (clk),
    .reset  (reset),
    .i_d    (CS_b_wire),
    .o_lvl  (w_cs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk    (clk),
    .reset  (reset),
    .i_d    (MOSI_to_sensor),
    .o_lvl  (w_mosi),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  assign w_unused_sync = w_sclk_lvl ^ w_mosi_rise ^ w_mosi_fall;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Frame sequencing: start, accept full frame or reject short one.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_accept = 1'b0;
    w_short  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cs_fall || r_pend) begin
          w_next  = S_SHIFT;
          w_start = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          if (r_cnt >= FULL) begin
            w_next   = S_DONE;
            w_accept = 1'b1;
          end else begin
            w_next  = S_IDLE;
            w_short = 1'b1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_op   = r_cmd_word[15:14];
  assign w_addr = r_cmd_word[13:8];
  assign w_data = r_cmd_word[7:0];

  assign w_rdata = (w_addr >= RO_BASE)
                 ? ro_value(w_addr[1:0], 8'(N_CHANNELS))
                 : r_regs[w_addr];

  // Command decode: reply word and side effects.
  always_comb begin
    w_reply    = '0;
    w_wr_en    = 1'b0;
    w_conv_inc = 1'b0;
    unique case (1'b1)
      (w_op == OP_CONVERT): begin
        if (32'(w_addr) < N_CHANNELS) begin
          w_reply    = {w_addr, r_conv};
          w_conv_inc = 1'b1;
        end else begin
          w_reply = REPLY_DEAD;
        end
      end
      (w_op == OP_WRITE): begin
        w_reply = {8'hFF, w_data};
        w_wr_en = (w_addr < RO_BASE);
      end
      (w_op == OP_READ):  w_reply = {8'h00, w_rdata};
      (w_op == OP_DUMMY): w_reply = '0;
      default:            w_reply = '0;
    endcase
  end

  // Bit capture, reply shift-out and held CS edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_tx        <= '0;
      r_pend      <= 1'b0;
      r_cmd_word  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_short;
      if (w_start) begin
        r_cnt  <= '0;
        r_tx   <= r_pipe[0];
        r_pend <= 1'b0;
      end else if (r_state == S_DONE && w_cs_fall) begin
        r_pend <= 1'b1;
      end
      if (r_state == S_SHIFT) begin
        if (w_sclk_rise && r_cnt < FULL) begin
          r_shift <= {r_shift[WORD_W-2:0], w_mosi};
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        if (w_sclk_fall) r_tx <= {r_tx[WORD_W-2:0], 1'b0};
      end
      if (w_accept) r_cmd_word <= r_shift;
    end
  end

  // Command execution: reply pipeline, conversion count, registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) r_pipe[i] <= '0;
      for (int i = 0; i < 64; i++) r_regs[i] <= '0;
      r_conv <= '0;
    end else if (r_state == S_DONE) begin
      for (int i = 0; i < PIPE_DEPTH - 1; i++) r_pipe[i] <= r_pipe[i+1];
      r_pipe[PIPE_DEPTH-1] <= w_reply;
      if (w_conv_inc) r_conv <= r_conv + 10'd1;
      if (w_wr_en) r_regs[w_addr] <= w_data;
    end
  end

  assign MISO_from_sensor = (r_state == S_SHIFT) & ~w_cs_lvl & r_tx[WORD_W-1];
  assign cmd_valid        = (r_state == S_DONE);
  assign cmd_word         = r_cmd_word;
  assign frame_err        = r_frame_err;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Self-checking bench for spi_sensor_responder.
// Drives SPI frames and compares replies to a behavioural model.
module tb_spi_sensor_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        SCLK_wire = 1'b0;
  logic        CS_b_wire = 1'b1;
  logic        MOSI_to_sensor = 1'b0;
  logic        MISO_from_sensor;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt     = 0;
  int ecnt     = 0;

  logic [15:0] mq [$];
  logic [7:0]  mregs [64];
  int          mconv;

  spi_sensor_responder #(
    .WORD_W(16), .N_CHANNELS(32), .PIPE_DEPTH(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .SCLK_wire        (SCLK_wire),
    .CS_b_wire        (CS_b_wire),
    .MOSI_to_sensor   (MOSI_to_sensor),
    .MISO_from_sensor (MISO_from_sensor),
    .cmd_valid        (cmd_valid),
    .cmd_word         (cmd_word),
    .frame_err        (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (cmd_valid) vcnt++;
      if (frame_err) ecnt++;
    end
  end

  task automatic model_reset();
    mq.delete();
    mq.push_back(16'h0000);
    mq.push_back(16'h0000);
    for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
    mconv = 0;
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a == 60) return 8'h01;
    if (a == 61) return 8'h53;
    if (a == 62) return 8'h49;
    if (a == 63) return 8'd32;
    return mregs[a];
  endfunction

  function automatic logic [15:0] model_cmd(input logic [15:0] c);
    int op, a;
    logic [7:0] d;
    op = int'(c[15:14]);
    a  = int'(c[13:8]);
    d  = c[7:0];
    if (op == 0) begin
      if (a < 32) begin
        model_cmd = {6'(a), 10'(mconv)};
        mconv = (mconv + 1) % 1024;
      end else begin
        model_cmd = 16'hDEAD;
      end
    end else if (op == 2) begin
      if (a < 60) mregs[a] = d;
      model_cmd = {8'hFF, d};
    end else if (op == 3) begin
      model_cmd = {8'h00, model_read(a)};
    end else begin
      model_cmd = 16'h0000;
    end
  endfunction

  function automatic logic [15:0] exp_step(input logic [15:0] c);
    logic [15:0] e;
    e = mq.pop_front();
    mq.push_back(model_cmd(c));
    return e;
  endfunction

  task automatic do_frame(
    input  logic [15:0] cmd,
    input  int          nbits,
    input  int          h,
    input  int          gap,
    output logic [15:0] rx,
    output logic        tail
  );
    rx   = '0;
    tail = 1'b0;
    CS_b_wire = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      MOSI_to_sensor = (i < 16) ? cmd[15-i] : 1'($urandom);
      repeat (h) @(negedge clk);
      SCLK_wire = 1'b1;
      if (i < 16) rx[15-i] = MISO_from_sensor;
      else tail = tail | MISO_from_sensor;
      repeat (h) @(negedge clk);
      SCLK_wire = 1'b0;
    end
    repeat (h) @(negedge clk);
    CS_b_wire = 1'b1;
    MOSI_to_sensor = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (MISO_from_sensor !== 1'b0 || cmd_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset_outs got miso=%b v=%b e=%b exp 0 0 0",
               MISO_from_sensor, cmd_valid, frame_err);
    else n_pass++;
    n_checks++;
    if (cmd_word !== 16'h0000)
      $display("FAIL reset_word got=%h exp=0000", cmd_word);
    else n_pass++;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    n_checks++;
    if (MISO_from_sensor !== 1'b0 || cmd_valid !== 1'b0 || vcnt != 0)
      $display("FAIL post_reset got miso=%b vcnt=%0d exp 0 0",
               MISO_from_sensor, vcnt);
    else n_pass++;
  endtask

  task automatic test_pipeline();
    logic [15:0] cmds [4];
    logic [15:0] lit  [4];
    logic [15:0] rx, e;
    logic        t;
    int          v0;
    cmds = '{16'hFF00, 16'hFC00, 16'h4000, 16'h4000};
    lit  = '{16'h0000, 16'h0000, 16'h0020, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      v0 = vcnt;
      do_frame(cmds[i], 16, 6, 10, rx, t);
      e = exp_step(cmds[i]);
      n_checks++;
      if (rx !== lit[i] || rx !== e)
        $display("FAIL pipe_miso[%0d] got=%h exp=%h", i, rx, lit[i]);
      else n_pass++;
      n_checks++;
      if (vcnt != v0 + 1 || cmd_word !== cmds[i])
        $display("FAIL pipe_valid[%0d] got n=%0d w=%h exp n=1 w=%h",
                 i, vcnt - v0, cmd_word, cmds[i]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    logic [15:0] cmds [6];
    logic [15:0] rx, e;
    logic        t;
    cmds = '{16'h85A7, 16'hC500, 16'hBD00, 16'hFD00, 16'h4000, 16'h4000};
    for (int i = 0; i < 6; i++) begin
      do_frame(cmds[i], 16, 6, 10, rx, t);
      e = exp_step(cmds[i]);
      n_checks++;
      if (rx !== e)
        $display("FAIL wr_miso[%0d] got=%h exp=%h", i, rx, e);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (rx !== 16'h00A7)
          $display("FAIL rd_back got=%h exp=00A7", rx);
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if (rx !== 16'h0053)
          $display("FAIL ro_protect got=%h exp=0053", rx);
        else n_pass++;
      end
    end
  endtask

  task automatic test_convert();
    logic [15:0] cmds [8];
    logic [15:0] rx, e;
    logic        t;
    cmds = '{16'h0300, 16'h0300, 16'h0300, 16'h4000, 16'h4000,
             16'h2800, 16'h0300, 16'h4000};
    for (int i = 0; i < 8; i++) begin
      do_frame(cmds[i], 16, 6, 10, rx, t);
      e = exp_step(cmds[i]);
      n_checks++;
      if (rx !== e)
        $display("FAIL conv_miso[%0d] got=%h exp=%h", i, rx, e);
      else n_pass++;
    end
    do_frame(16'h4000, 16, 6, 10, rx, t);
    e = exp_step(16'h4000);
    n_checks++;
    if (rx !== 16'h0C03 || rx !== e)
      $display("FAIL conv_dead_nocount got=%h exp=0C03", rx);
    else n_pass++;
  endtask

  task automatic test_short_frame();
    logic [15:0] rx, e;
    logic        t;
    int          v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    do_frame(16'h8512, 9, 6, 10, rx, t);
    n_checks++;
    if (ecnt != e0 + 1 || vcnt != v0)
      $display("FAIL short_frame got err=%0d valid=%0d exp 1 0",
               ecnt - e0, vcnt - v0);
    else n_pass++;
    do_frame(16'h4000, 16, 6, 10, rx, t);
    e = exp_step(16'h4000);
    n_checks++;
    if (rx !== e)
      $display("FAIL short_next got=%h exp=%h", rx, e);
    else n_pass++;
  endtask

  task automatic test_extra_bits();
    logic [15:0] rx, e;
    logic        t;
    do_frame(16'hFE00, 18, 6, 10, rx, t);
    e = exp_step(16'hFE00);
    n_checks++;
    if (rx !== e || t !== 1'b0 || cmd_word !== 16'hFE00)
      $display("FAIL extra_bits got rx=%h tail=%b w=%h exp %h 0 FE00",
               rx, t, cmd_word, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] cmds [4];
    logic [15:0] rxs  [4];
    int          gaps [4];
    logic [15:0] e;
    logic        t;
    int          v0;
    cmds = '{16'hC700, 16'h8733, 16'hC700, 16'h4000};
    gaps = '{2, 1, 2, 10};
    v0 = vcnt;
    for (int i = 0; i < 4; i++) do_frame(cmds[i], 16, 6, gaps[i], rxs[i], t);
    for (int i = 0; i < 4; i++) begin
      e = exp_step(cmds[i]);
      n_checks++;
      if (rxs[i] !== e)
        $display("FAIL b2b_miso[%0d] got=%h exp=%h", i, rxs[i], e);
      else n_pass++;
    end
    n_checks++;
    if (vcnt != v0 + 4)
      $display("FAIL b2b_count got=%0d exp=4", vcnt - v0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] cmds [5];
    logic [15:0] rx, e;
    logic        t;
    int          v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    CS_b_wire = 1'b0;
    for (int i = 0; i < 8; i++) begin
      MOSI_to_sensor = 1'b1;
      repeat (6) @(negedge clk);
      SCLK_wire = 1'b1;
      repeat (6) @(negedge clk);
      SCLK_wire = 1'b0;
    end
    reset = 1'b0;
    CS_b_wire = 1'b1;
    MOSI_to_sensor = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    model_reset();
    n_checks++;
    if (vcnt != v0 || ecnt != e0 || cmd_word !== 16'h0000)
      $display("FAIL rst_abort got v=%0d e=%0d w=%h exp 0 0 0000",
               vcnt - v0, ecnt - e0, cmd_word);
    else n_pass++;
    cmds = '{16'h4000, 16'h4000, 16'hC500, 16'h4000, 16'h4000};
    for (int i = 0; i < 5; i++) begin
      do_frame(cmds[i], 16, 6, 10, rx, t);
      e = exp_step(cmds[i]);
      n_checks++;
      if (rx !== e || (i != 2 && i != 3 && rx !== 16'h0000))
        $display("FAIL rst_miso[%0d] got=%h exp=%h", i, rx, e);
      else n_pass++;
    end
  endtask

  task automatic test_stress();
    logic [15:0] c, rx, e;
    logic        t;
    int          v0, h;
    for (int i = 0; i < 24; i++) begin
      c[15:14] = 2'($urandom_range(0, 3));
      c[13:8]  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7))
                                             : 6'($urandom_range(0, 63));
      c[7:0]   = 8'($urandom);
      h  = $urandom_range(5, 7);
      v0 = vcnt;
      do_frame(c, 16, h, $urandom_range(2, 6), rx, t);
      repeat (6) @(negedge clk);
      e = exp_step(c);
      n_checks++;
      if (rx !== e)
        $display("FAIL stress_miso[%0d] cmd=%h got=%h exp=%h", i, c, rx, e);
      else n_pass++;
      n_checks++;
      if (cmd_word !== c || vcnt != v0 + 1)
        $display("FAIL stress_word[%0d] got=%h n=%0d exp=%h n=1",
                 i, cmd_word, vcnt - v0, c);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_write_read();
    test_convert();
    test_short_frame();
    test_extra_bits();
    test_back_to_back();
    test_reset_mid_frame();
    test_stress();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
